// File: rtl/flash_arbiter_pkg.sv
// flash_arbiter_pkg
// Shared types and constants for the flash arbiter slice.
//   state_t       : arbiter FSM encoding (IDLE, BUSY, DONE)
//   GRANT_CPU/AUX : value held in the grant register / grant_aux output
//   FLASH_ADDR_W  : flash byte address width
//   DATA_W        : flash read data width
package flash_arbiter_pkg;

    localparam int FLASH_ADDR_W = 24;
    localparam int DATA_W       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_AUX = 1'b1;

    // A cached 32-bit word also satisfies a 16-bit request; a cached
    // 16-bit result cannot satisfy a 32-bit request.
    function automatic logic size_covers(input logic cached_size, input logic req_size);
        return cached_size | ~req_size;
    endfunction

endpackage

// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if
// Bundles both requester ports, the flash_reader port, the cache
// invalidate input and the grant_aux debug output.
//   slave  : arbiter side (takes requests, drives flash_reader)
//   master : environment side (requesters + flash_reader model)
interface flash_arbiter_if;
    import flash_arbiter_pkg::*;

    logic                    cpu_valid;
    logic [FLASH_ADDR_W-1:0] cpu_address;
    logic                    cpu_size;
    logic [DATA_W-1:0]       cpu_data;
    logic                    cpu_ready;

    logic                    aux_valid;
    logic [FLASH_ADDR_W-1:0] aux_address;
    logic                    aux_size;
    logic [DATA_W-1:0]       aux_data;
    logic                    aux_ready;

    logic                    cache_invalidate;

    logic                    flash_valid;
    logic [FLASH_ADDR_W-1:0] flash_address;
    logic                    flash_size;
    logic [DATA_W-1:0]       flash_data;
    logic                    flash_ready;

    logic                    grant_aux;

    modport slave (
        input  cpu_valid, cpu_address, cpu_size,
        output cpu_data, cpu_ready,
        input  aux_valid, aux_address, aux_size,
        output aux_data, aux_ready,
        input  cache_invalidate,
        output flash_valid, flash_address, flash_size,
        input  flash_data, flash_ready,
        output grant_aux
    );

    modport master (
        output cpu_valid, cpu_address, cpu_size,
        input  cpu_data, cpu_ready,
        output aux_valid, aux_address, aux_size,
        input  aux_data, aux_ready,
        output cache_invalidate,
        input  flash_valid, flash_address, flash_size,
        output flash_data, flash_ready,
        input  grant_aux
    );

endinterface

// File: rtl/flash_arbiter_cache.sv
// flash_arbiter_cache
// One-entry read result cache (tag = full byte address, size, data, valid).
// Only compiled when FLASH_ARBITER_CACHE_EN is defined.
//   clk, reset_n        : clock, async active-low reset (entry invalid)
//   invalidate_i        : clears the valid bit on the next edge, wins over fill
//   lookup_addr_i/size_i: request being arbitrated; hit_o/data_o combinational
//   fill_en_i/addr/size/data : completed flash read to store
`ifdef FLASH_ARBITER_CACHE_EN
module flash_arbiter_cache
    import flash_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    invalidate_i,
    input  logic [FLASH_ADDR_W-1:0] lookup_addr_i,
    input  logic                    lookup_size_i,
    input  logic                    fill_en_i,
    input  logic [FLASH_ADDR_W-1:0] fill_addr_i,
    input  logic                    fill_size_i,
    input  logic [DATA_W-1:0]       fill_data_i,
    output logic                    hit_o,
    output logic [DATA_W-1:0]       data_o
);

    logic                    valid_q;
    logic [FLASH_ADDR_W-1:0] tag_q;
    logic                    size_q;
    logic [DATA_W-1:0]       data_q;

    // Hit detection for the request currently being arbitrated.
    always_comb begin
        hit_o = 1'b0;
        if (valid_q && (tag_q == lookup_addr_i) && size_covers(size_q, lookup_size_i)) begin
            hit_o = 1'b1;
        end else begin
            hit_o = 1'b0;
        end
    end

    assign data_o = data_q;

    // Entry storage: fill on every completed flash read, invalidate wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            tag_q   <= {FLASH_ADDR_W{1'b0}};
            size_q  <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
        end else begin
            if (fill_en_i) begin
                tag_q  <= fill_addr_i;
                size_q <= fill_size_i;
                data_q <= fill_data_i;
            end
            if (invalidate_i) begin
                valid_q <= 1'b0;
            end else if (fill_en_i) begin
                valid_q <= 1'b1;
            end else begin
                valid_q <= valid_q;
            end
        end
    end

endmodule
`endif

// File: rtl/flash_arbiter.sv
// flash_arbiter
// Shares one flash_reader between the CPU (priority) and an aux master.
// One flash transaction at a time: IDLE arbitrates, BUSY holds flash_valid
// until flash_ready, DONE issues a one-cycle ready to the granted requester.
// CPU_BURST_MAX bounds consecutive CPU grants while aux is waiting.
// Optional macro FLASH_ARBITER_CACHE_EN adds a one-entry result cache.
// Ports:
//   clk, reset_n : clock, async active-low reset (all outputs 0)
//   bus          : flash_arbiter_if.slave (cpu_*, aux_*, flash_*,
//                  cache_invalidate, grant_aux)
module flash_arbiter
    import flash_arbiter_pkg::*;
#(
    parameter int unsigned CPU_BURST_MAX = 4
)
(
    input  logic              clk,
    input  logic              reset_n,
    flash_arbiter_if.slave    bus
);

    localparam logic [3:0] BURST_LIMIT = 4'(CPU_BURST_MAX);

    state_t                  state_q;
    logic [3:0]              burst_q;
    logic [3:0]              burst_d;
    logic                    grant_q;
    logic                    drop_q;
    logic                    flash_valid_q;
    logic [FLASH_ADDR_W-1:0] flash_address_q;
    logic                    flash_size_q;
    logic [DATA_W-1:0]       cpu_data_q;
    logic [DATA_W-1:0]       aux_data_q;
    logic                    cpu_ready_q;
    logic                    aux_ready_q;

    logic                    pick_aux_s;
    logic                    req_any_s;
    logic [FLASH_ADDR_W-1:0] req_addr_s;
    logic                    req_size_s;
    logic                    gnt_valid_s;
    logic                    hit_s;
    logic [DATA_W-1:0]       hit_data_s;

    // Winner selection: CPU unless aux waits and the CPU burst is used up.
    always_comb begin
        pick_aux_s = 1'b0;
        if (bus.aux_valid && (!bus.cpu_valid || (burst_q == BURST_LIMIT))) begin
            pick_aux_s = 1'b1;
        end else begin
            pick_aux_s = 1'b0;
        end
    end

    assign req_any_s   = bus.cpu_valid | bus.aux_valid;
    assign req_addr_s  = pick_aux_s ? bus.aux_address : bus.cpu_address;
    assign req_size_s  = pick_aux_s ? bus.aux_size    : bus.cpu_size;
    assign gnt_valid_s = (grant_q == GRANT_AUX) ? bus.aux_valid : bus.cpu_valid;

    // Burst counter update for an IDLE cycle (only counts while aux waits).
    always_comb begin
        burst_d = burst_q;
        if (!bus.aux_valid || pick_aux_s) begin
            burst_d = 4'd0;
        end else if (burst_q != 4'hF) begin
            burst_d = burst_q + 4'd1;
        end else begin
            burst_d = burst_q;
        end
    end

`ifdef FLASH_ARBITER_CACHE_EN
    logic fill_en_s;
    assign fill_en_s = (state_q == BUSY) && bus.flash_ready;

    flash_arbiter_cache u_cache (
        .clk           (clk),
        .reset_n       (reset_n),
        .invalidate_i  (bus.cache_invalidate),
        .lookup_addr_i (req_addr_s),
        .lookup_size_i (req_size_s),
        .fill_en_i     (fill_en_s),
        .fill_addr_i   (flash_address_q),
        .fill_size_i   (flash_size_q),
        .fill_data_i   (bus.flash_data),
        .hit_o         (hit_s),
        .data_o        (hit_data_s)
    );
`else
    logic unused_cache_s;
    assign unused_cache_s = bus.cache_invalidate;
    assign hit_s          = 1'b0;
    assign hit_data_s     = {DATA_W{1'b0}};
`endif

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            burst_q         <= 4'd0;
            grant_q         <= GRANT_CPU;
            drop_q          <= 1'b0;
            flash_valid_q   <= 1'b0;
            flash_address_q <= {FLASH_ADDR_W{1'b0}};
            flash_size_q    <= 1'b0;
            cpu_data_q      <= {DATA_W{1'b0}};
            aux_data_q      <= {DATA_W{1'b0}};
            cpu_ready_q     <= 1'b0;
            aux_ready_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    burst_q <= burst_d;
                    if (req_any_s) begin
                        grant_q <= pick_aux_s;
                        drop_q  <= 1'b0;
                        if (hit_s) begin
                            // Cache hit: skip flash entirely.
                            state_q <= DONE;
                            if (pick_aux_s) begin
                                aux_data_q  <= hit_data_s;
                                aux_ready_q <= 1'b1;
                            end else begin
                                cpu_data_q  <= hit_data_s;
                                cpu_ready_q <= 1'b1;
                            end
                        end else begin
                            flash_address_q <= req_addr_s;
                            flash_size_q    <= req_size_s;
                            flash_valid_q   <= 1'b1;
                            state_q         <= BUSY;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    // Remember if the owner let go at any point; its result is then dropped.
                    if (!gnt_valid_s) begin
                        drop_q <= 1'b1;
                    end else begin
                        drop_q <= drop_q;
                    end
                    if (bus.flash_ready) begin
                        flash_valid_q <= 1'b0;
                        state_q       <= DONE;
                        if (!drop_q && gnt_valid_s) begin
                            if (grant_q == GRANT_AUX) begin
                                aux_data_q  <= bus.flash_data;
                                aux_ready_q <= 1'b1;
                            end else begin
                                cpu_data_q  <= bus.flash_data;
                                cpu_ready_q <= 1'b1;
                            end
                        end else begin
                            cpu_ready_q <= 1'b0;
                            aux_ready_q <= 1'b0;
                        end
                    end else begin
                        state_q <= BUSY;
                    end
                end
                DONE: begin
                    cpu_ready_q <= 1'b0;
                    aux_ready_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q       <= IDLE;
                    flash_valid_q <= 1'b0;
                    cpu_ready_q   <= 1'b0;
                    aux_ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flash_valid   = flash_valid_q;
    assign bus.flash_address = flash_address_q;
    assign bus.flash_size    = flash_size_q;
    assign bus.cpu_data      = cpu_data_q;
    assign bus.cpu_ready     = cpu_ready_q;
    assign bus.aux_data      = aux_data_q;
    assign bus.aux_ready     = aux_ready_q;
    assign bus.grant_aux     = grant_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter
// Directed bench for flash_arbiter with a flash_reader model and a
// scoreboard of expected ready pulses (requester, grant_aux, data).
// Cache scenario is included when FLASH_ARBITER_CACHE_EN is defined.
module tb_flash_arbiter;
    import flash_arbiter_pkg::*;

    typedef struct {
        logic        aux;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   lat;
    int   fcnt;
    bit   cpu_done_seen;
    bit   aux_start_seen;
    bit   aux_after;
    exp_t sb_q[$];

    flash_arbiter_if bus();

    flash_arbiter #(.CPU_BURST_MAX(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        if (a == 24'h001000) return 32'hDEADBEEF;
        else                 return {8'h5A, a};
    endfunction

    // Flash_reader model: ready for one cycle after lat cycles of valid.
    always @(negedge clk) begin
        if (bus.flash_ready) begin
            bus.flash_ready = 1'b0;
            fcnt = 0;
        end else if (bus.flash_valid) begin
            fcnt++;
            if (fcnt >= lat) begin
                bus.flash_ready = 1'b1;
                bus.flash_data  = flash_word(bus.flash_address);
            end
        end else begin
            fcnt = 0;
        end
    end

    // Scoreboard monitor: every ready pulse pops and checks one expectation.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] got;
        if (reset_n && (bus.cpu_ready || bus.aux_ready)) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ready cpu_ready=%0b aux_ready=%0b, none expected",
                         bus.cpu_ready, bus.aux_ready);
            end else begin
                e   = sb_q.pop_front();
                got = e.aux ? bus.aux_data : bus.cpu_data;
                if (bus.cpu_ready == e.aux || bus.aux_ready != e.aux ||
                    bus.grant_aux != e.aux || got != e.data) begin
                    n_err++;
                    $display("FAIL ready_txn got cpu_ready=%0b aux_ready=%0b grant_aux=%0b data=%h, expected aux=%0b data=%h",
                             bus.cpu_ready, bus.aux_ready, bus.grant_aux, got, e.aux, e.data);
                end
            end
        end
    end

    // Ordering watcher: aux flash access must start after CPU completion.
    always @(negedge clk) begin
        if (bus.cpu_ready) cpu_done_seen = 1'b1;
        if (bus.flash_valid && bus.flash_address == 24'h080000 && !aux_start_seen) begin
            aux_start_seen = 1'b1;
            aux_after      = cpu_done_seen;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic cpu_txn(input logic [23:0] a, input logic s, input bit keep);
        bit got;
        got = 1'b0;
        bus.cpu_address = a;
        bus.cpu_size    = s;
        bus.cpu_valid   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.cpu_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL cpu_timeout addr=%h no cpu_ready within 300 cycles", a);
        end
        if (!keep) bus.cpu_valid = 1'b0;
    endtask

    task automatic aux_txn(input logic [23:0] a, input logic s);
        bit got;
        got = 1'b0;
        bus.aux_address = a;
        bus.aux_size    = s;
        bus.aux_valid   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.aux_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL aux_timeout addr=%h no aux_ready within 300 cycles", a);
        end
        bus.aux_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        n_cmp = 0; n_err = 0; lat = 3; fcnt = 0;
        cpu_done_seen = 1'b0; aux_start_seen = 1'b0; aux_after = 1'b0;
        bus.cpu_valid = 1'b0; bus.cpu_address = 24'h0; bus.cpu_size = 1'b0;
        bus.aux_valid = 1'b0; bus.aux_address = 24'h0; bus.aux_size = 1'b0;
        bus.cache_invalidate = 1'b0;
        bus.flash_data = 32'h0; bus.flash_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_flash_valid", {31'd0, bus.flash_valid}, 32'd0);
        check("rst_cpu_ready",   {31'd0, bus.cpu_ready},   32'd0);
        check("rst_aux_ready",   {31'd0, bus.aux_ready},   32'd0);
        check("rst_cpu_data",    bus.cpu_data,             32'd0);
        check("rst_grant_aux",   {31'd0, bus.grant_aux},   32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: CPU 32-bit read, flash_ready on cycle 20.
        lat = 20;
        sb_q.push_back('{1'b0, 32'hDEADBEEF});
        bus.cpu_address = 24'h001000; bus.cpu_size = 1'b1; bus.cpu_valid = 1'b1;
        @(negedge clk);
        check("t1_fv_cycle1", {31'd0, bus.flash_valid}, 32'd1);
        check("t1_flash_addr", {8'd0, bus.flash_address}, 32'h00001000);
        check("t1_flash_size", {31'd0, bus.flash_size}, 32'd1);
        ok = 1'b1;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (!bus.flash_valid || bus.cpu_ready) ok = 1'b0;
        end
        check("t1_fv_held_2_20", {31'd0, ok}, 32'd1);
        @(negedge clk);
        check("t1_ready_cycle21", {31'd0, bus.cpu_ready}, 32'd1);
        check("t1_fv_low_cycle21", {31'd0, bus.flash_valid}, 32'd0);
        bus.cpu_valid = 1'b0;
        @(negedge clk);

        // 2: simultaneous requests, CPU first.
        lat = 3;
        cpu_done_seen = 1'b0; aux_start_seen = 1'b0; aux_after = 1'b0;
        sb_q.push_back('{1'b0, 32'h5A000100});
        sb_q.push_back('{1'b1, 32'h5A080000});
        fork
            cpu_txn(24'h000100, 1'b1, 1'b0);
            aux_txn(24'h080000, 1'b1);
        join
        check("t2_aux_after_cpu", {31'd0, aux_after}, 32'd1);
        @(negedge clk);

        // 3: burst limit 4 -> C,C,C,C,A,C.
        sb_q.push_back('{1'b0, 32'h5A000200});
        sb_q.push_back('{1'b0, 32'h5A000204});
        sb_q.push_back('{1'b0, 32'h5A000208});
        sb_q.push_back('{1'b0, 32'h5A00020C});
        sb_q.push_back('{1'b1, 32'h5A090000});
        sb_q.push_back('{1'b0, 32'h5A000210});
        fork
            begin
                cpu_txn(24'h000200, 1'b1, 1'b1);
                cpu_txn(24'h000204, 1'b1, 1'b1);
                cpu_txn(24'h000208, 1'b1, 1'b1);
                cpu_txn(24'h00020C, 1'b1, 1'b1);
                cpu_txn(24'h000210, 1'b1, 1'b0);
            end
            aux_txn(24'h090000, 1'b1);
        join
        @(negedge clk);

        // 4: reset mid-BUSY.
        lat = 20;
        bus.cpu_address = 24'h003000; bus.cpu_size = 1'b1; bus.cpu_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_busy_fv", {31'd0, bus.flash_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t4_rst_fv",       {31'd0, bus.flash_valid}, 32'd0);
        check("t4_rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
        check("t4_rst_cpu_data", bus.cpu_data, 32'd0);
        check("t4_rst_aux_data", bus.aux_data, 32'd0);
        check("t4_rst_faddr", {8'd0, bus.flash_address}, 32'd0);
        bus.cpu_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        lat = 3;
        sb_q.push_back('{1'b0, 32'h5A000400});
        cpu_txn(24'h000400, 1'b0, 1'b0);
        @(negedge clk);

        // 5: aux drops mid-BUSY, pending CPU served next.
        lat = 6;
        bus.aux_address = 24'h0A0000; bus.aux_size = 1'b1; bus.aux_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.aux_valid = 1'b0;
        sb_q.push_back('{1'b0, 32'h5A000500});
        bus.cpu_address = 24'h000500; bus.cpu_size = 1'b0; bus.cpu_valid = 1'b1;
        ok = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            if (!bus.flash_valid) ok = 1'b0;
        end
        check("t5_fv_held", {31'd0, ok}, 32'd1);
        cpu_txn(24'h000500, 1'b0, 1'b0);
        @(negedge clk);

`ifdef FLASH_ARBITER_CACHE_EN
        // 6: cache hit, size-covered hit, invalidate -> miss.
        lat = 3;
        sb_q.push_back('{1'b0, 32'h5A002000});
        cpu_txn(24'h002000, 1'b1, 1'b0);
        @(negedge clk);
        sb_q.push_back('{1'b0, 32'h5A002000});
        bus.cpu_address = 24'h002000; bus.cpu_size = 1'b1; bus.cpu_valid = 1'b1;
        @(negedge clk);
        check("t6_hit32_ready", {31'd0, bus.cpu_ready}, 32'd1);
        check("t6_hit32_no_fv", {31'd0, bus.flash_valid}, 32'd0);
        bus.cpu_valid = 1'b0;
        @(negedge clk);
        sb_q.push_back('{1'b0, 32'h5A002000});
        bus.cpu_size = 1'b0; bus.cpu_valid = 1'b1;
        @(negedge clk);
        check("t6_hit16_ready", {31'd0, bus.cpu_ready}, 32'd1);
        check("t6_hit16_no_fv", {31'd0, bus.flash_valid}, 32'd0);
        bus.cpu_valid = 1'b0;
        @(negedge clk);
        bus.cache_invalidate = 1'b1;
        @(negedge clk);
        bus.cache_invalidate = 1'b0;
        sb_q.push_back('{1'b0, 32'h5A002000});
        bus.cpu_size = 1'b1; bus.cpu_valid = 1'b1;
        @(negedge clk);
        check("t6_inv_fv", {31'd0, bus.flash_valid}, 32'd1);
        check("t6_inv_no_ready", {31'd0, bus.cpu_ready}, 32'd0);
        cpu_txn(24'h002000, 1'b1, 1'b0);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
- Shares the single flash_reader port between two requesters: CPU instruction/data fetch (priority) and an auxiliary bus master (DMA/asset loader).
- Sits directly in front of flash_reader and drives its valid/address/size.
- Sequences one flash transaction at a time, so flash_reader never sees overlapping or back-to-back-merged requests.
- Returns registered data with a one-cycle ready pulse to the granted requester.

Parameters:
- CPU_BURST_MAX, 4: consecutive CPU grants allowed while aux is pending before aux is forced in. Range 1..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_valid  in  1  CPU request; held with address/size until cpu_ready
- cpu_address  in  24  CPU flash byte address
- cpu_size  in  1  0 = 16-bit, 1 = 32-bit
- cpu_data  out  32  read result, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- aux_valid, aux_address, aux_size, aux_data, aux_ready: same as cpu_*, for the aux requester
- cache_invalidate  in  1  clears the cache entry (ignored when the cache is compiled out)
- flash_valid  out  1  to flash_reader valid
- flash_address  out  24  to flash_reader address
- flash_size  out  1  to flash_reader size
- flash_data  in  32  from flash_reader data
- flash_ready  in  1  from flash_reader ready
- grant_aux  out  1  1 while the current/last grant is aux (debug)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all outputs 0.
  - Burst counter 0; cache entry invalid.
  - Takes effect immediately mid-transaction; flash_valid falling low halts flash_reader.
- States:
  - IDLE: arbitrate, register the winner's address/size into flash_address/flash_size, set flash_valid=1, go to BUSY. If there is no request, stay.
  - BUSY: flash_valid held at 1. On flash_ready=1: capture flash_data into the granted requester's data register, clear flash_valid, go to DONE. flash_valid is therefore 0 on the cycle after flash_ready, so flash_reader cannot restart.
  - DONE: granted requester's ready=1 for exactly one cycle; requests are not sampled; next state IDLE. Requesters must update valid before the following cycle.
- Arbitration (IDLE only):
  - Only cpu_valid: grant CPU. Only aux_valid: grant aux.
  - Both valid: grant CPU unless burst_cnt==CPU_BURST_MAX, in which case grant aux.
  - burst_cnt: +1 on each CPU grant made while aux_valid=1, saturating. Cleared on an aux grant, or in IDLE when aux_valid=0.
- Latency (uncached): request seen in IDLE at cycle 0 -> flash_valid=1 at cycle 1 -> requester ready at (flash_ready cycle)+1.
- Requester drops valid while BUSY: the transaction still runs to flash_ready, data is discarded, and no ready pulse is issued (DONE is still traversed).
- The cpu_ready and aux_ready pulses never overlap. The non-granted data register holds its last value.
- flash_address/flash_size change only in IDLE and are stable for the whole of BUSY.

Optional Feature:
- Macro FLASH_ARBITER_CACHE_EN.
- Enabled: one-entry result cache (tag = 24-bit address, cached size, valid).
  - Filled on every completed flash read.
  - Hit in IDLE when the tag matches and cached size >= requested size. On a hit: go straight to DONE with cached data, no flash_valid, ready at cycle 1.
  - A hit still counts as a grant for burst_cnt.
  - cache_invalidate clears the valid bit on the next edge, and has priority over a same-cycle fill.
- Disabled: no cache logic; cache_invalidate unused; every request goes to flash.

Decomposition:
- Package flash_arbiter_pkg:
  - state encoding (IDLE, BUSY, DONE)
  - GRANT_CPU/GRANT_AUX constants
  - FLASH_ADDR_W=24, DATA_W=32
- Sub-module flash_arbiter_cache: the tag/data/valid entry with lookup, fill and invalidate. Instantiated only under FLASH_ARBITER_CACHE_EN.

Test Plan:
1. CPU-only 32-bit read of 0x001000; flash model returns 0xDEADBEEF with flash_ready at cycle 20 -> flash_valid=1 on cycles 1..20; cpu_ready=1 at cycle 21 with cpu_data=0xDEADBEEF; flash_valid=0 at cycle 21.
2. cpu_valid and aux_valid rise together (0x000100, 0x080000) -> CPU served first; aux gets flash_address=0x080000 only after the CPU's DONE; ready pulses never coincide.
3. CPU_BURST_MAX=4, CPU re-requests continuously, aux held valid -> grant order CPU,CPU,CPU,CPU,AUX,CPU...; grant_aux=1 exactly on the 5th transaction.
4. reset_n pulled low mid-BUSY -> flash_valid, ready and data outputs read 0 in the same cycle; after release, a new CPU request starts cleanly from IDLE.
5. aux_valid dropped mid-BUSY -> flash_valid held until flash_ready; no aux_ready pulse; a pending CPU request is granted next.
6. With FLASH_ARBITER_CACHE_EN, repeat a 32-bit read of 0x002000 -> cpu_ready at cycle 1 with no flash_valid; then a 16-bit read of the same address also hits. Assert cache_invalidate, then repeat -> goes to flash.
